// File: rtl/piso8_tx.sv
// Framed parallel-in/serial-out transmitter. It accepts one word over a valid/ready
// handshake and sends a start bit (0), WIDTH data bits and a stop bit (1), one bit per En tick.
module piso8_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             Clk,
   input  logic             Res,
   input  logic             En,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   // Counter wide enough to reach WIDTH-1; WIDTH=1 still needs one bit.
   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;

   // State register with asynchronous abort of any frame in flight.
   always_ff @(posedge Clk or negedge Res) begin
      if (!Res) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: the handshake fires only in idle, and every later step waits for En.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_valid) begin
               shift_d = load_data;
               cnt_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (En) state_d = StData;
         end
         StData: begin
            if (En) begin
               // Shift toward the output end, zero-filling behind.
               shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
               if (cnt_q == LastCnt) begin
                  cnt_d   = '0;
                  state_d = StStop;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StStop: begin
            if (En) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and shift register only, never from inputs.
   always_comb begin
      ser_out = 1'b1;
      unique case (state_q)
         StIdle:  ser_out = 1'b1;
         StStart: ser_out = 1'b0;
         StData:  ser_out = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
         StStop:  ser_out = 1'b1;
         default: ser_out = 1'b1;
      endcase
      load_ready = (state_q == StIdle);
      busy       = (state_q != StIdle);
      done       = done_q;
   end

endmodule

// File: tb/tb_piso8_tx.sv
// Bench for piso8_tx: one LSB-first and one MSB-first instance share the clock, reset and En.
// Expected line bits are queued when a word is loaded and popped at each En sample.
module tb_piso8_tx;

   logic       Clk = 1'b0;
   logic       Res = 1'b0;
   logic       En  = 1'b0;
   logic       lv_a = 1'b0, lv_b = 1'b0;
   logic [7:0] ld_a = '0, ld_b = '0;
   logic       lr_a, lr_b, ser_a, ser_b, busy_a, busy_b, done_a, done_b;

   int n_run  = 0;
   int n_fail = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   logic exp_q[$];

   always #5 Clk = ~Clk;

   piso8_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
      .Clk(Clk), .Res(Res), .En(En), .load_valid(lv_a), .load_ready(lr_a),
      .load_data(ld_a), .ser_out(ser_a), .busy(busy_a), .done(done_a)
   );

   piso8_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
      .Clk(Clk), .Res(Res), .En(En), .load_valid(lv_b), .load_ready(lr_b),
      .load_data(ld_b), .ser_out(ser_b), .busy(busy_b), .done(done_b)
   );

   always @(negedge Clk) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   function automatic logic ser(input bit sel);
      return sel ? ser_b : ser_a;
   endfunction
   function automatic logic bsy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction
   function automatic logic rdy(input bit sel);
      return sel ? lr_b : lr_a;
   endfunction
   function automatic logic dne(input bit sel);
      return sel ? done_b : done_a;
   endfunction
   function automatic int dcnt(input bit sel);
      return sel ? done_cnt_b : done_cnt_a;
   endfunction

   task automatic set_load(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin lv_b = v; ld_b = d; end
      else begin lv_a = v; ld_a = d; end
   endtask

   task automatic push_frame(input bit lsb_first, input logic [7:0] w);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(lsb_first ? w[i] : w[7-i]);
      exp_q.push_back(1'b1);
   endtask

   task automatic check_idle(input bit sel, input string tag);
      n_run++;
      if ({ser(sel), rdy(sel), bsy(sel), dne(sel)} !== 4'b1100) begin
         n_fail++;
         $display("FAIL %s dut%0d: ser/rdy/busy/done=%b%b%b%b expected 1100", tag, sel,
                  ser(sel), rdy(sel), bsy(sel), dne(sel));
      end
   endtask

   // Present a word for one edge; the frame is expected to start right after it.
   task automatic start_load(input bit sel, input logic [7:0] w);
      set_load(sel, 1'b1, w);
      push_frame(!sel, w);
      @(posedge Clk); #1;
      set_load(sel, 1'b0, 8'h00);
   endtask

   // gap idle cycles (line must be busy, not ready), then one En cycle whose bit is compared.
   task automatic bit_tick(input bit sel, input int gap);
      logic e;
      for (int i = 0; i < gap; i++) begin
         @(negedge Clk);
         n_run++;
         if (bsy(sel) !== 1'b1 || rdy(sel) !== 1'b0 || dne(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL in_frame dut%0d: busy=%b ready=%b done=%b expected 1 0 0", sel,
                     bsy(sel), rdy(sel), dne(sel));
         end
         @(posedge Clk); #1;
      end
      En = 1'b1;
      @(negedge Clk);
      n_run++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL line_bit dut%0d: got %b but no bit expected", sel, ser(sel));
      end else begin
         e = exp_q.pop_front();
         if (ser(sel) !== e || bsy(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL line_bit dut%0d: ser=%b busy=%b expected ser=%b busy=1", sel,
                     ser(sel), bsy(sel), e);
         end
      end
      @(posedge Clk); #1;
      En = 1'b0;
   endtask

   // Called just after the final En edge: done for exactly one cycle, then quiet idle.
   task automatic finish_frame(input bit sel, input int cnt_before);
      @(negedge Clk);
      n_run++;
      if (dne(sel) !== 1'b1 || bsy(sel) !== 1'b0 || rdy(sel) !== 1'b1 || ser(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL done_pulse dut%0d: done=%b busy=%b ready=%b ser=%b expected 1 0 1 1",
                  sel, dne(sel), bsy(sel), rdy(sel), ser(sel));
      end
      @(posedge Clk); #1;
      @(negedge Clk);
      check_idle(sel, "after_done");
      @(posedge Clk); #1;
      n_run++;
      if (dcnt(sel) !== cnt_before + 1) begin
         n_fail++;
         $display("FAIL done_count dut%0d: got %0d expected %0d", sel, dcnt(sel), cnt_before + 1);
      end
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_bits: %0d unsent expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] w, input int gap);
      int c;
      c = dcnt(sel);
      start_load(sel, w);
      for (int i = 0; i < 10; i++) bit_tick(sel, gap);
      finish_frame(sel, c);
   endtask

   task automatic test_reset();
      Res = 1'b0;
      for (int i = 0; i < 8; i++) begin
         En = 1'($urandom_range(0, 1));
         set_load(0, 1'($urandom_range(0, 1)), 8'($urandom));
         set_load(1, 1'($urandom_range(0, 1)), 8'($urandom));
         @(negedge Clk);
         check_idle(0, "in_reset");
         check_idle(1, "in_reset");
         @(posedge Clk); #1;
      end
      En = 1'b0;
      set_load(0, 1'b0, 8'h00);
      set_load(1, 1'b0, 8'h00);
      Res = 1'b1;
      for (int i = 0; i < 20; i++) begin
         En = (i % 4 == 3);
         @(negedge Clk);
         check_idle(0, "idle_no_load");
         check_idle(1, "idle_no_load");
         @(posedge Clk); #1;
      end
      En = 1'b0;
   endtask

   task automatic test_lsb_frame();
      send_frame(0, 8'hA5, 3);
   endtask

   task automatic test_msb_frame();
      send_frame(1, 8'h3C, 3);
   endtask

   task automatic test_back_to_back();
      int c;
      c = done_cnt_a;
      start_load(0, 8'hFF);
      for (int i = 0; i < 10; i++) bit_tick(0, 2);
      // Done cycle: offer the next word immediately.
      set_load(0, 1'b1, 8'h00);
      push_frame(1'b1, 8'h00);
      @(negedge Clk);
      n_run++;
      if (done_a !== 1'b1 || lr_a !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done_ready: done=%b ready=%b expected 1 1", done_a, lr_a);
      end
      @(posedge Clk); #1;
      set_load(0, 1'b0, 8'h00);
      n_run++;
      if (busy_a !== 1'b1 || ser_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_start: busy=%b ser=%b expected 1 0", busy_a, ser_a);
      end
      for (int i = 0; i < 10; i++) bit_tick(0, 2);
      finish_frame(0, c + 1);
   endtask

   task automatic test_busy_reject();
      int c;
      c = done_cnt_a;
      start_load(0, 8'h81);
      for (int i = 0; i < 3; i++) bit_tick(0, 2);
      set_load(0, 1'b1, 8'h7E);
      @(negedge Clk);
      n_run++;
      if (lr_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reject_ready: ready=%b expected 0", lr_a);
      end
      @(posedge Clk); #1;
      set_load(0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) bit_tick(0, 2);
      finish_frame(0, c);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check_idle(0, "no_ghost_frame");
         @(posedge Clk); #1;
      end
   endtask

   task automatic test_reset_mid_frame();
      int c;
      c = done_cnt_a;
      start_load(0, 8'h55);
      for (int i = 0; i < 4; i++) bit_tick(0, 2);
      #3;
      Res = 1'b0;
      #1;
      check_idle(0, "async_abort");
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk); #1;
      end
      Res = 1'b1;
      for (int i = 0; i < 3; i++) begin
         En = (i == 1);
         @(negedge Clk);
         check_idle(0, "post_abort");
         @(posedge Clk); #1;
      end
      En = 1'b0;
      n_run++;
      if (done_cnt_a !== c) begin
         n_fail++;
         $display("FAIL abort_no_done: done count %0d expected %0d", done_cnt_a, c);
      end
      send_frame(0, 8'h12, 1);
   endtask

   task automatic test_en_continuous();
      send_frame(0, 8'h5A, 0);
      send_frame(1, 8'hC3, 0);
   endtask

   initial begin
      test_reset();
      test_lsb_frame();
      test_msb_frame();
      test_back_to_back();
      test_busy_reject();
      test_reset_mid_frame();
      test_en_continuous();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/piso8_tx.md
Name: piso8_tx

Overview:
Parallel-in, serial-out framed transmitter. It accepts an 8-bit word from a register-side producer through a valid/ready handshake. It then shifts the word out on a single line as start bit (0), WIDTH data bits, and stop bit (1), one bit per En tick. It is the transmit end of the byte path whose receive end captures words into 8-bit registers; En is the shared bit-rate tick.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 1..16)
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
Clk  input  1  system clock, all state changes on rising edge
Res  input  1  asynchronous reset, active-low
En  input  1  bit-period tick; one-cycle pulse marks end of the current bit period
load_valid  input  1  producer has a word on load_data
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to transmit
ser_out  output  1  serial line, idle high
busy  output  1  frame in progress (START, DATA or STOP state)
done  output  1  one-cycle pulse after stop bit completes

Behaviour:
- Clocking and reset: Clk is the only clock. Res is asynchronous and active-low.
- Reset (Res=0, asynchronous): state=IDLE, ser_out=1, load_ready=1, busy=0, done=0, shift register=0, bit counter=0.
- Reset mid-frame aborts the frame. ser_out returns to 1 immediately, with no partial stop bit and no done pulse.
- States: IDLE, START, DATA, STOP. All outputs are registered or decoded from state/shift register only; there is no combinational path from inputs to outputs.
- IDLE:
  - ser_out=1, load_ready=1, busy=0.
  - Handshake fires on a rising edge with load_valid=1 and load_ready=1. load_data is captured into the shift register, counter is cleared, and the next state is START. En is irrelevant for acceptance.
  - En pulses in IDLE are ignored.
- START:
  - ser_out=0, busy=1, load_ready=0.
  - On the first edge with En=1, go to DATA.
  - The start bit therefore lasts from acceptance to the next En. The first bit may be shorter than a full period; this is accepted behaviour.
- DATA:
  - ser_out = shift[0] if LSB_FIRST=1, else shift[WIDTH-1].
  - On each edge with En=1:
    - shift toward the output end, filling with 0;
    - counter increments;
    - if counter==WIDTH-1 before the increment, go to STOP and clear the counter.
  - Each data bit is held for exactly one En-to-En period.
- STOP:
  - ser_out=1, busy=1.
  - On an edge with En=1, go to IDLE and set done=1 for exactly one cycle (the first IDLE cycle).
- Back-to-back frames: load_ready is 1 in the same cycle that done=1. A word presented then is accepted on that edge, and START begins the next cycle, so the line sees no extra idle bit.
- load_valid while load_ready=0 is ignored. The producer holds data until the handshake fires. load_data changes after acceptance do not affect the frame in flight.
- En held high continuously advances one bit per Clk cycle, which is legal.
- Frame length: exactly WIDTH+2 En ticks from acceptance to done.

Test Plan:
1. Reset: hold Res=0 with random inputs -> ser_out=1, load_ready=1, busy=0, done=0. Release Res, drive no load -> outputs unchanged for 20 cycles and 5 En pulses.
2. LSB-first frame, WIDTH=8: load 0xA5, En every 4 cycles -> ser_out sampled just before each En reads 0,1,0,1,0,0,1,0,1,1. done pulses once, 1 cycle, after the 10th En. busy is high from the cycle after acceptance until done.
3. MSB-first (LSB_FIRST=0): load 0x3C -> data bits 0,0,1,1,1,1,0,0, framed by 0 and 1.
4. Back-to-back: load 0xFF, hold load_valid with 0x00 ready during the done cycle -> 0x00 accepted on the done edge, no idle gap. Line reads 0,1x8,1,0,0x8,1.
5. Busy rejection: during the DATA state of 0x81, pulse load_valid with 0x7E -> ignored, load_ready=0, and the 0x81 bit sequence is unaltered.
6. Reset mid-frame: assert Res=0 after the 3rd data bit of 0x55 -> ser_out=1 asynchronously and no done pulse. After release, a new load of 0x12 transmits correctly.
